// File: rtl/crc_check_unit.sv
// CRC-8 checking responder: accepts a 64-bit word (56-bit payload + received CRC)
// on an active-low enable, recomputes the CRC one byte per clock, reports done/error.
module crc_check_unit #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crcEn,
    input  logic [63:0] dataIn,
    output logic [1:0]  crcStatus,
    output logic [7:0]  crcValue
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [55:0] shreg_q, shreg_d;
    logic [7:0]  rx_crc_q, rx_crc_d;
    logic [7:0]  crc_q, crc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  status_q, status_d;
    logic [7:0]  value_q, value_d;
    logic [7:0]  crc_next;

    // MSB-first, non-reflected byte update, fully unrolled
    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in);
        logic [7:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    assign crc_next = crc8_byte(crc_q ^ shreg_q[55:48]);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        rx_crc_d = rx_crc_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        value_d  = value_q;
        case (state_q)
            IDLE: begin
                status_d = 2'b10;
                if (!crcEn) begin
                    shreg_d  = dataIn[63:8];
                    rx_crc_d = dataIn[7:0];
                    crc_d    = INIT;
                    cnt_d    = 3'd0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (crcEn) begin
                    state_d  = IDLE;
                    status_d = 2'b10;
                end else begin
                    crc_d   = crc_next;
                    shreg_d = {shreg_q[47:0], 8'h00};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd6) begin
                        state_d  = DONE;
                        value_d  = crc_next;
                        status_d = {1'b0, crc_next != rx_crc_q};
                    end
                end
            end
            DONE: begin
                // result held until the controller releases the request
                if (crcEn) begin
                    state_d  = IDLE;
                    status_d = 2'b10;
                end
            end
            default: begin
                state_d  = IDLE;
                status_d = 2'b10;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shreg_q  <= 56'h0;
            rx_crc_q <= 8'h00;
            crc_q    <= 8'h00;
            cnt_q    <= 3'd0;
            status_q <= 2'b10;
            value_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            rx_crc_q <= rx_crc_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            value_q  <= value_d;
        end
    end

    assign crcStatus = status_q;
    assign crcValue  = value_q;

endmodule

// File: tb/tb_crc_check_unit.sv
// Directed bench for crc_check_unit: hand-computed CRC-8 (poly 0x07) vectors,
// cycle-exact status latency, abort, hold, re-arm and asynchronous reset.
module tb_crc_check_unit;

    logic        clk;
    logic        rst;
    logic        crcEn;
    logic [63:0] dataIn;
    logic [1:0]  crcStatus;
    logic [7:0]  crcValue;

    int checks;
    int failures;

    crc_check_unit #(.POLY(8'h07), .INIT(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .crcEn     (crcEn),
        .dataIn    (dataIn),
        .crcStatus (crcStatus),
        .crcValue  (crcValue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // E0 accept, busy through E6, result at E7
    task automatic run(input string tag, input logic [63:0] w,
                       input logic [1:0] est, input logic [7:0] ev);
        dataIn = w;
        crcEn  = 1'b0;
        tick();
        chk({tag, "_e0"}, crcStatus, 2'b10);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk({tag, "_busy"}, crcStatus, 2'b10);
        end
        tick();
        chk({tag, "_st"}, crcStatus, est);
        chk({tag, "_val"}, crcValue, ev);
    endtask

    task automatic release_chk(input string tag, input logic [7:0] ev);
        crcEn = 1'b1;
        tick();
        chk({tag, "_rel_st"}, crcStatus, 2'b10);
        chk({tag, "_rel_val"}, crcValue, ev);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        crcEn    = 1'b1;
        dataIn   = 64'h0;
        #2 rst = 1'b0;
        #2;
        chk("reset_st", crcStatus, 2'b10);
        chk("reset_val", crcValue, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("idle_st", crcStatus, 2'b10);

        run("zero", 64'h0, 2'b00, 8'h00);
        release_chk("zero", 8'h00);
        run("pass", 64'h0000_0000_0000_0107, 2'b00, 8'h07);
        release_chk("pass", 8'h07);
        run("mis", 64'h0000_0000_0000_8000, 2'b01, 8'h89);
        release_chk("mis", 8'h89);
        run("fix", 64'h0000_0000_0000_8089, 2'b00, 8'h89);
        release_chk("fix", 8'h89);
        // two payload bytes 0x01,0x00 -> 0x07 then table[0x07] = 0x15
        run("two_ok", 64'h0000_0000_0001_0015, 2'b00, 8'h15);
        release_chk("two_ok", 8'h15);
        run("two_bad", 64'h0000_0000_0001_0000, 2'b01, 8'h15);
        release_chk("two_bad", 8'h15);

        // abort: raise crcEn sampled at E3
        dataIn = 64'h0000_0000_0000_0107;
        crcEn  = 1'b0;
        tick();
        tick();
        tick();
        crcEn = 1'b1;
        tick();
        chk("abort_st", crcStatus, 2'b10);
        chk("abort_val", crcValue, 8'h15);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("abort_nodone", crcStatus, 2'b10);
        end

        // hold in DONE for 20 cycles: no restart
        run("hold", 64'h0000_0000_0000_020E, 2'b00, 8'h0E);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("hold_st", crcStatus, 2'b00);
            chk("hold_val", crcValue, 8'h0E);
        end
        release_chk("hold", 8'h0E);

        // dataIn changes after E0 must not affect the result
        dataIn = 64'h0000_0000_0000_8000;
        crcEn  = 1'b0;
        tick();
        dataIn = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("chg_busy", crcStatus, 2'b10);
        end
        tick();
        chk("chg_st", crcStatus, 2'b01);
        chk("chg_val", crcValue, 8'h89);
        release_chk("chg", 8'h89);

        // back-to-back with exactly one crcEn=1 edge between
        run("b2b_a", 64'h0000_0000_0000_0107, 2'b00, 8'h07);
        release_chk("b2b_a", 8'h07);
        run("b2b_b", 64'h0000_0000_0000_8000, 2'b01, 8'h89);
        release_chk("b2b_b", 8'h89);

        // asynchronous reset mid-CALC
        dataIn = 64'h0000_0000_0000_0107;
        crcEn  = 1'b0;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_st", crcStatus, 2'b10);
        chk("rst_mid_val", crcValue, 8'h00);
        crcEn = 1'b1;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_rel_st", crcStatus, 2'b10);
        end
        run("post_rst", 64'h0000_0000_0000_0107, 2'b00, 8'h07);
        release_chk("post_rst", 8'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_check_unit.md
Name: crc_check_unit

Overview:
- CRC-8 checking responder on the bus comparator's CRC enable/status handshake; one instance per CPU channel.
- Receives an active-low enable and a 64-bit word (56-bit payload plus 8-bit CRC).
- Recomputes the CRC one byte per clock and reports done/error on a 2-bit status bus to the comparator controller.

Parameters:
- POLY, 8'h07, CRC-8 generator polynomial. MSB-first, non-reflected, no final XOR.
- INIT, 8'h00, CRC register preset value loaded at each accepted request.

Ports:
- clk  input  1  system clock, rising edge. This is the only clock.
- rst  input  1  reset, asynchronous, active-low.
- crcEn  input  1  request from the controller, active-low: 0 = run/hold, 1 = release.
- dataIn  input  64  word under check. [63:8] = payload bytes, MSB byte first. [7:0] = received CRC.
- crcStatus  output  2  [1]: 1 = waiting/busy, 0 = done. [0]: 0 = CRC match, 1 = mismatch. Only meaningful when [1]=0.
- crcValue  output  8  computed CRC, for debug/logging. Valid when crcStatus[1]=0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, crcStatus=2'b10, crcValue=8'h00, byte counter=0, shift register=0.
- States: IDLE, CALC, DONE. All transitions occur on the clk rising edge.
- IDLE:
  - crcStatus is held at 2'b10.
  - At an edge E0 that samples crcEn=0: latch dataIn[63:8] into a 56-bit shift register, latch dataIn[7:0] as rxCrc, set crc=INIT, cnt=0, go to CALC.
  - dataIn is sampled only at E0; later changes are ignored.
- CALC, edges E1..E7, one payload byte per edge:
  - Byte order: [63:56] first, [15:8] last.
  - Per edge: crc = crc8_byte(crc ^ topByte, POLY), 8 unrolled shift/XOR steps, MSB-first. Then shift the register left by 8 and increment cnt.
  - At E7 (cnt==6 before the edge): go to DONE. In the same edge set crcValue = new crc and crcStatus = {1'b0, (new crc != rxCrc)}.
  - Latency: crcStatus[1] falls exactly 7 clocks after the accepting edge E0.
- DONE:
  - Hold crcStatus and crcValue while crcEn=0.
  - At the first edge sampling crcEn=1: go to IDLE and set crcStatus=2'b10. crcValue keeps its last value.
- Abort: crcEn=1 sampled in CALC → go to IDLE at that edge, crcStatus=2'b10, no result produced.
- Re-arm: a new request requires at least one edge sampling crcEn=1 after DONE. A crcEn held low through DONE never starts a second run.
- Compatibility with the controller: it drives crcEn=1 on the edge it observes crcStatus[1]=0. The unit then returns to 2'b10 one cycle later. Status[0] must be stable from E7 until that release edge.
- Reset asserted mid-CALC or mid-DONE: immediate return to the reset values above. After reset release the unit stays in IDLE until crcEn=0 is sampled.
- crcStatus is never 2'b11. Every status bit comes directly from a register, with no combinational path from crcEn or dataIn.

Test Plan:
- Reset values: assert rst=0 mid-CALC → crcStatus=2'b10 and crcValue=8'h00 immediately, without waiting for a clock edge. Release rst with crcEn=1 → status stays 2'b10.
- All-zero word: dataIn=64'h0, crcEn=0 at E0 → crcStatus=2'b10 through E6. At E7 crcStatus=2'b00, crcValue=8'h00.
- Pass case: dataIn=64'h0000_0000_0000_0107 (last payload byte 0x01 → CRC 0x07) → at E7 crcStatus=2'b00, crcValue=8'h07. Drive crcEn=1 → crcStatus=2'b10 on the next edge.
- Mismatch: dataIn=64'h0000_0000_0000_8000 (last payload byte 0x80 → CRC 0x89, received 0x00) → at E7 crcStatus=2'b01, crcValue=8'h89. Repeat with 64'h0000_0000_0000_8089 → crcStatus=2'b00.
- Abort and hold:
  - Raise crcEn at E3 → IDLE, no done pulse.
  - Hold crcEn=0 for 20 cycles after DONE → crcStatus stays 2'b00 with no restart.
  - Change dataIn during CALC → result unchanged.
- Back-to-back: two requests separated by exactly one crcEn=1 cycle, with different words → two correct results, each 7 cycles after its own acceptance edge.
